// File: rtl/uart_receiver_checker.sv
// Pattern checker behind a UART receiver: locks onto a 4-byte repeating
// pattern (sync byte PAT0) and counts matching bytes and errors.
module uart_receiver_checker #(
  parameter logic [7:0] PAT0 = 8'hAA,
  parameter logic [7:0] PAT1 = 8'h55,
  parameter logic [7:0] PAT2 = 8'hCC,
  parameter logic [7:0] PAT3 = 8'h89
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  Rx_DATA,
  input  logic        Rx_VALID,
  input  logic        Rx_FERROR,
  input  logic        Rx_PERROR,
  output logic        LOCKED,
  output logic [1:0]  EXP_IDX,
  output logic [7:0]  LAST_BYTE,
  output logic [15:0] GOOD_CNT,
  output logic [7:0]  ERR_CNT,
  output logic        CHK_PULSE,
  output logic        CHK_OK
);

  typedef enum logic {SYNC, TRACK} state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx_nxt;
  logic [7:0]  last_nxt;
  logic [15:0] good_nxt;
  logic [7:0]  err_nxt;
  logic        ok_nxt;
  logic [7:0]  exp_byte;
  logic [15:0] good_inc;
  logic [7:0]  err_inc;
  logic        line_err;

  always_comb begin
    exp_byte = PAT0;
    case (EXP_IDX)
      2'd0: exp_byte = PAT0;
      2'd1: exp_byte = PAT1;
      2'd2: exp_byte = PAT2;
      2'd3: exp_byte = PAT3;
      default: exp_byte = PAT0;
    endcase
  end

  assign line_err = Rx_FERROR | Rx_PERROR;
  assign good_inc = (GOOD_CNT == 16'hFFFF) ? GOOD_CNT : GOOD_CNT + 16'd1;
  assign err_inc  = (ERR_CNT == 8'hFF) ? ERR_CNT : ERR_CNT + 8'd1;

  always_comb begin
    state_nxt = state;
    idx_nxt   = EXP_IDX;
    last_nxt  = LAST_BYTE;
    good_nxt  = GOOD_CNT;
    err_nxt   = ERR_CNT;
    ok_nxt    = CHK_OK;
    if (Rx_VALID) begin
      ok_nxt = 1'b0;
      if (line_err) begin
        // Corrupted frame: drop the byte and force a fresh sync.
        if (state == TRACK) err_nxt = err_inc;
        state_nxt = SYNC;
        idx_nxt   = 2'd0;
      end else begin
        last_nxt = Rx_DATA;
        case (state)
          SYNC: begin
            if (Rx_DATA == PAT0) begin
              state_nxt = TRACK;
              idx_nxt   = 2'd1;
              ok_nxt    = 1'b1;
            end else begin
              idx_nxt = 2'd0;
            end
          end
          TRACK: begin
            if (Rx_DATA == exp_byte) begin
              idx_nxt  = EXP_IDX + 2'd1;
              good_nxt = good_inc;
              ok_nxt   = 1'b1;
            end else begin
              err_nxt = err_inc;
              // A stray sync byte realigns without dropping lock.
              if (Rx_DATA == PAT0) begin
                idx_nxt = 2'd1;
              end else begin
                state_nxt = SYNC;
                idx_nxt   = 2'd0;
              end
            end
          end
          default: begin
            state_nxt = SYNC;
            idx_nxt   = 2'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= SYNC;
      EXP_IDX   <= 2'd0;
      LAST_BYTE <= 8'h00;
      GOOD_CNT  <= 16'h0000;
      ERR_CNT   <= 8'h00;
      CHK_PULSE <= 1'b0;
      CHK_OK    <= 1'b0;
    end else begin
      CHK_PULSE <= Rx_VALID;
      state     <= state_nxt;
      EXP_IDX   <= idx_nxt;
      LAST_BYTE <= last_nxt;
      GOOD_CNT  <= good_nxt;
      ERR_CNT   <= err_nxt;
      CHK_OK    <= ok_nxt;
    end
  end

  assign LOCKED = (state == TRACK);

endmodule

// File: tb/tb_uart_receiver_checker.sv
// Scoreboard bench: send() pushes the expected post-frame outputs, a negedge
// monitor pops one entry per CHK_PULSE; directed checks use hand constants.
module tb_uart_receiver_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  Rx_DATA;
  logic        Rx_VALID;
  logic        Rx_FERROR;
  logic        Rx_PERROR;
  logic        LOCKED;
  logic [1:0]  EXP_IDX;
  logic [7:0]  LAST_BYTE;
  logic [15:0] GOOD_CNT;
  logic [7:0]  ERR_CNT;
  logic        CHK_PULSE;
  logic        CHK_OK;

  uart_receiver_checker dut (
    .clk(clk), .reset(reset), .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID),
    .Rx_FERROR(Rx_FERROR), .Rx_PERROR(Rx_PERROR), .LOCKED(LOCKED),
    .EXP_IDX(EXP_IDX), .LAST_BYTE(LAST_BYTE), .GOOD_CNT(GOOD_CNT),
    .ERR_CNT(ERR_CNT), .CHK_PULSE(CHK_PULSE), .CHK_OK(CHK_OK)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ok;
    logic        locked;
    logic [1:0]  idx;
    logic [7:0]  last;
    logic [15:0] good;
    logic [7:0]  err;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   pulse_cnt = 0;

  // reference state
  logic        m_lock;
  logic [1:0]  m_idx;
  logic [7:0]  m_last;
  logic [15:0] m_good;
  logic [7:0]  m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] patf(input logic [1:0] i);
    logic [7:0] p;
    case (i)
      2'd0: p = 8'hAA;
      2'd1: p = 8'h55;
      2'd2: p = 8'hCC;
      default: p = 8'h89;
    endcase
    return p;
  endfunction

  task automatic model_reset();
    m_lock = 1'b0; m_idx = 2'd0; m_last = 8'h00; m_good = 16'h0; m_err = 8'h0;
  endtask

  task automatic send(input logic [7:0] d, input logic fe = 1'b0, input logic pe = 1'b0);
    exp_t e;
    logic ok;
    ok = 1'b0;
    if (fe || pe) begin
      if (m_lock && m_err != 8'hFF) m_err = m_err + 8'd1;
      m_lock = 1'b0; m_idx = 2'd0;
    end else begin
      m_last = d;
      if (!m_lock) begin
        if (d == 8'hAA) begin m_lock = 1'b1; m_idx = 2'd1; ok = 1'b1; end
      end else if (d == patf(m_idx)) begin
        m_idx = m_idx + 2'd1;
        if (m_good != 16'hFFFF) m_good = m_good + 16'd1;
        ok = 1'b1;
      end else begin
        if (m_err != 8'hFF) m_err = m_err + 8'd1;
        if (d == 8'hAA) m_idx = 2'd1;
        else begin m_lock = 1'b0; m_idx = 2'd0; end
      end
    end
    e = '{ok: ok, locked: m_lock, idx: m_idx, last: m_last, good: m_good, err: m_err};
    q.push_back(e);
    Rx_DATA = d; Rx_FERROR = fe; Rx_PERROR = pe; Rx_VALID = 1'b1;
    @(posedge clk);
    #1;
    Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
  endtask

  // let outstanding pulses be consumed, then settle at posedge+3
  task automatic drain();
    repeat (2) @(posedge clk);
    #3;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && CHK_PULSE === 1'b1) begin
      exp_t e;
      pulse_cnt++;
      if (q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        check("chk_ok", {31'd0, CHK_OK}, {31'd0, e.ok});
        check("locked", {31'd0, LOCKED}, {31'd0, e.locked});
        check("exp_idx", {30'd0, EXP_IDX}, {30'd0, e.idx});
        check("last_byte", {24'd0, LAST_BYTE}, {24'd0, e.last});
        check("good_cnt", {16'd0, GOOD_CNT}, {16'd0, e.good});
        check("err_cnt", {24'd0, ERR_CNT}, {24'd0, e.err});
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_locked"}, {31'd0, LOCKED}, 32'd0);
    check({tag, "_idx"}, {30'd0, EXP_IDX}, 32'd0);
    check({tag, "_last"}, {24'd0, LAST_BYTE}, 32'd0);
    check({tag, "_good"}, {16'd0, GOOD_CNT}, 32'd0);
    check({tag, "_err"}, {24'd0, ERR_CNT}, 32'd0);
    check({tag, "_pulse"}, {31'd0, CHK_PULSE}, 32'd0);
    check({tag, "_ok"}, {31'd0, CHK_OK}, 32'd0);
  endtask

  initial begin
    int p0;
    logic [7:0] seq [6];
    reset = 1'b0; Rx_DATA = 8'h00; Rx_VALID = 1'b0; Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
    model_reset();
    #3;
    check_reset_vals("por");
    #20 reset = 1'b1;
    @(posedge clk); #1;

    // clean stream 55,AA,55,CC,89,AA
    seq = '{8'h55, 8'hAA, 8'h55, 8'hCC, 8'h89, 8'hAA};
    p0 = pulse_cnt;
    foreach (seq[i]) send(seq[i]);
    drain();
    check("clean_pulses", pulse_cnt - p0, 32'd6);
    check("clean_good", {16'd0, GOOD_CNT}, 32'd4);
    check("clean_err", {24'd0, ERR_CNT}, 32'd0);
    check("clean_idx", {30'd0, EXP_IDX}, 32'd1);
    check("clean_locked", {31'd0, LOCKED}, 32'd1);

    // mismatch at idx 2 drops lock, AA relocks
    send(8'h55);
    send(8'h00);
    drain();
    check("mis_err", {24'd0, ERR_CNT}, 32'd1);
    check("mis_locked", {31'd0, LOCKED}, 32'd0);
    check("mis_ok", {31'd0, CHK_OK}, 32'd0);
    send(8'hAA);
    drain();
    check("relock_idx", {30'd0, EXP_IDX}, 32'd1);
    check("relock_locked", {31'd0, LOCKED}, 32'd1);

    // AA at idx 3 realigns without losing lock
    send(8'h55); send(8'hCC); send(8'hAA);
    drain();
    check("realign_err", {24'd0, ERR_CNT}, 32'd2);
    check("realign_locked", {31'd0, LOCKED}, 32'd1);
    check("realign_idx", {30'd0, EXP_IDX}, 32'd1);

    // parity error while locked, then again in SYNC
    send(8'hCC, 1'b0, 1'b1);
    drain();
    check("perr_last", {24'd0, LAST_BYTE}, 32'hAA);
    check("perr_err", {24'd0, ERR_CNT}, 32'd3);
    check("perr_locked", {31'd0, LOCKED}, 32'd0);
    send(8'hCC, 1'b0, 1'b1);
    send(8'h12, 1'b1, 1'b0);
    drain();
    check("perr_sync_err", {24'd0, ERR_CNT}, 32'd3);
    check("perr_sync_last", {24'd0, LAST_BYTE}, 32'hAA);

    // framing error while locked
    send(8'hAA); send(8'h55, 1'b1, 1'b0);
    drain();
    check("ferr_err", {24'd0, ERR_CNT}, 32'd4);
    check("ferr_idx", {30'd0, EXP_IDX}, 32'd0);

    // inputs ignored while Rx_VALID is low
    send(8'hAA);
    Rx_DATA = 8'h55; Rx_FERROR = 1'b1; Rx_PERROR = 1'b1;
    repeat (4) @(posedge clk);
    #3;
    Rx_FERROR = 1'b0; Rx_PERROR = 1'b0;
    check("idle_idx", {30'd0, EXP_IDX}, 32'd1);
    check("idle_last", {24'd0, LAST_BYTE}, 32'hAA);
    check("idle_locked", {31'd0, LOCKED}, 32'd1);
    check("idle_pulse", {31'd0, CHK_PULSE}, 32'd0);

    // async reset between edges while locked
    send(8'h55);
    drain();
    reset = 1'b0;
    #1;
    check_reset_vals("mid");
    model_reset();
    #10 reset = 1'b1;
    @(posedge clk); #1;
    send(8'h55);
    drain();
    check("post_rst_ok", {31'd0, CHK_OK}, 32'd0);
    check("post_rst_locked", {31'd0, LOCKED}, 32'd0);

    // ERR_CNT saturation: lock then 300 sync bytes, each a realign mismatch
    send(8'hAA);
    for (int i = 0; i < 300; i++) send(8'hAA);
    drain();
    check("err_sat", {24'd0, ERR_CNT}, 32'hFF);
    check("err_sat_locked", {31'd0, LOCKED}, 32'd1);

    // GOOD_CNT saturation: fresh start, 65540-byte pattern cycle
    reset = 1'b0; #2; model_reset(); reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 65540; i++) begin
      logic [1:0] k;
      k = i[1:0];
      send(patf(k));
    end
    drain();
    check("good_sat", {16'd0, GOOD_CNT}, 32'hFFFF);
    check("good_sat_err", {24'd0, ERR_CNT}, 32'd0);

    check("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_receiver_checker.md
UART_RECEIVER_CHECKER -- requirements
Module: uart_receiver_checker

Interface
REQ-001 Parameter PAT0, default 8'hAA: expected byte at pattern index 0, which is also the sync byte.
REQ-002 Parameter PAT1, default 8'h55: expected byte at pattern index 1.
REQ-003 Parameter PAT2, default 8'hCC: expected byte at pattern index 2.
REQ-004 Parameter PAT3, default 8'h89: expected byte at pattern index 3.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 Rx_DATA  input  8  received byte, sampled only when Rx_VALID=1.
REQ-008 Rx_VALID  input  1  one-cycle pulse per received frame; back-to-back pulses are separate frames.
REQ-009 Rx_FERROR  input  1  framing error for the frame flagged by Rx_VALID.
REQ-010 Rx_PERROR  input  1  parity error for the frame flagged by Rx_VALID.
REQ-011 LOCKED  output  1  high while the checker is in state TRACK.
REQ-012 EXP_IDX  output  2  pattern index expected next.
REQ-013 LAST_BYTE  output  8  last byte accepted without frame or parity error.
REQ-014 GOOD_CNT  output  16  count of matching bytes while in TRACK, saturating at 16'hFFFF.
REQ-015 ERR_CNT  output  8  count of mismatches and line errors, saturating at 8'hFF.
REQ-016 CHK_PULSE  output  1  one-cycle pulse, one clock after each Rx_VALID.
REQ-017 CHK_OK  output  1  result of the last check, valid while CHK_PULSE=1.

Function
REQ-018 The FSM SHALL have exactly two states, SYNC and TRACK; all registers SHALL update only on a clk edge with Rx_VALID=1, except CHK_PULSE, which clears on the following edge.
REQ-019 SYNC with a clean frame and Rx_DATA==PAT0: go to TRACK, set EXP_IDX=1, CHK_OK=1; GOOD_CNT unchanged.
REQ-020 SYNC with a clean frame and Rx_DATA!=PAT0: stay in SYNC, keep EXP_IDX=0, CHK_OK=0; ERR_CNT unchanged (pre-lock bytes are not errors).
REQ-021 TRACK with a clean frame and Rx_DATA==PAT[EXP_IDX]: stay in TRACK, EXP_IDX+1 wrapping 3->0, GOOD_CNT+1, CHK_OK=1.
REQ-022 TRACK with a clean frame and Rx_DATA!=PAT[EXP_IDX]: ERR_CNT+1, CHK_OK=0; if Rx_DATA==PAT0, stay in TRACK with EXP_IDX=1 (immediate realign); otherwise go to SYNC with EXP_IDX=0.
REQ-023 Any frame with Rx_FERROR or Rx_PERROR high SHALL be a line error, which takes precedence over comparison: byte discarded, LAST_BYTE unchanged, CHK_OK=0, go to SYNC, EXP_IDX=0.
REQ-024 A line error SHALL increment ERR_CNT only in TRACK; in SYNC it is ignored apart from CHK_PULSE.
REQ-025 LAST_BYTE SHALL load Rx_DATA on every clean frame in either state.
REQ-026 GOOD_CNT and ERR_CNT SHALL saturate and never wrap.
REQ-027 CHK_PULSE SHALL go high on the edge after the Rx_VALID edge (latency 1) and stay high exactly one cycle; consecutive Rx_VALID cycles SHALL give consecutive pulses.
REQ-028 LOCKED SHALL equal (state==TRACK), driven directly from the registered state.
REQ-029 Rx_FERROR, Rx_PERROR and Rx_DATA SHALL be ignored while Rx_VALID=0.

Reset
REQ-030 While reset=0: state=SYNC, LOCKED=0, EXP_IDX=0, LAST_BYTE=8'h00, GOOD_CNT=0, ERR_CNT=0, CHK_PULSE=0, CHK_OK=0, asynchronously and regardless of clk.
REQ-031 Reset asserted mid-stream SHALL abandon the current check; the first Rx_VALID after release SHALL be treated as arriving in SYNC.
REQ-032 After reset is released, the first state change SHALL occur on the first clk edge with Rx_VALID=1.

Verification
REQ-033 Clean stream 55,AA,55,CC,89,AA -> SYNC after byte 1, LOCKED after byte 2, GOOD_CNT=4, ERR_CNT=0, EXP_IDX=1, six CHK_PULSEs (CHK_OK 0,1,1,1,1,1).
REQ-034 Locked at EXP_IDX=2, then byte 8'h00 -> CHK_OK=0, ERR_CNT=1, LOCKED=0; a following 8'hAA relocks with EXP_IDX=1.
REQ-035 Locked at EXP_IDX=3, then byte 8'hAA -> ERR_CNT+1, LOCKED stays 1, EXP_IDX=1.
REQ-036 Locked, then frame 8'hCC with Rx_PERROR=1 -> LAST_BYTE unchanged, ERR_CNT+1, SYNC; the same frame arriving in SYNC -> ERR_CNT unchanged.
REQ-037 Force ERR_CNT to 8'hFF via 300 mismatches -> ERR_CNT holds 8'hFF; GOOD_CNT saturation checked with PAT-cycle stream of 65540 bytes -> 16'hFFFF.
REQ-038 reset pulsed low between clk edges while locked -> all outputs at reset values immediately; next 8'h55 after release -> CHK_OK=0, LOCKED=0.
